// File: rtl/memory_game_ctrl_pkg.sv
// Shared types and constants for the 4x4 memory-game controller:
// FSM state encoding, grid geometry and the fixed card layout.
package memory_game_ctrl_pkg;

  typedef enum logic [2:0] {
    SEL1 = 3'd0,
    SEL2 = 3'd1,
    CMP  = 3'd2,
    SHOW = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int GRID  = 16;
  localparam int PAIRS = 8;

  // Pair ID for each card position, three bits per card, position 15 in the top slice.
  localparam logic [3*GRID-1:0] LAYOUT = {
    3'd7, 3'd4, 3'd6, 3'd3, 3'd5, 3'd2, 3'd1, 3'd7,
    3'd6, 3'd5, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0
  };

  function automatic logic [2:0] pair_id(input logic [3:0] pos);
    return LAYOUT[int'(pos)*3 +: 3];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/memory_game_ctrl_if.sv
// Button inputs and renderer/status outputs of the memory-game controller.
interface memory_game_ctrl_if;
  logic        start;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_sel;
  logic [3:0]  cursor_pos;
  logic [15:0] face_up;
  logic [15:0] matched;
  logic [3:0]  score;
  logic [7:0]  attempts;
  logic        game_done;

  modport master (
    output start, btn_up, btn_down, btn_left, btn_right, btn_sel,
    input  cursor_pos, face_up, matched, score, attempts, game_done
  );

  modport slave (
    input  start, btn_up, btn_down, btn_left, btn_right, btn_sel,
    output cursor_pos, face_up, matched, score, attempts, game_done
  );
endinterface

// File: rtl/memory_game_ctrl_reveal_timer.sv
// Countdown for how long a mismatched pair stays visible; done_o pulses on the
// last enabled cycle so the owner leaves SHOW after exactly REVEAL_CYCLES cycles.
module reveal_timer #(
  parameter int REVEAL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);
  localparam int CW = $clog2(REVEAL_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (load_i)                  cnt_d = CW'(REVEAL_CYCLES);
    else if (en_i && cnt_q != '0)     cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = en_i && !clr_i && (cnt_q == CW'(1));
endmodule

// File: rtl/memory_game_ctrl.sv
// Memory-game controller: cursor movement, two-card selection, pair comparison,
// timed reveal of mismatches and game completion on a fixed 4x4 layout.
module memory_game_ctrl
  import memory_game_ctrl_pkg::*;
#(
  parameter int REVEAL_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  memory_game_ctrl_if.slave  gif
);
  state_e      state_q, state_d;
  logic [3:0]  cursor_q, cursor_d;
  logic [15:0] face_up_q, face_up_d;
  logic [15:0] matched_q, matched_d;
  logic [3:0]  score_q, score_d;
  logic [7:0]  attempts_q, attempts_d;
  logic [3:0]  first_q, first_d;
  logic [3:0]  second_q, second_d;
  logic        tmr_load, tmr_clr, tmr_done;

  reveal_timer #(.REVEAL_CYCLES(REVEAL_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tmr_clr),
    .load_i (tmr_load),
    .en_i   (state_q == SHOW),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    face_up_d  = face_up_q;
    matched_d  = matched_q;
    score_d    = score_q;
    attempts_d = attempts_q;
    first_d    = first_q;
    second_d   = second_q;
    tmr_load   = 1'b0;
    tmr_clr    = 1'b0;

    if (gif.start) begin
      state_d    = SEL1;
      cursor_d   = '0;
      face_up_d  = '0;
      matched_d  = '0;
      score_d    = '0;
      attempts_d = '0;
      tmr_clr    = 1'b1;
    end else begin
      unique case (state_q)
        SEL1, SEL2: begin
          // A select press swallows any move pulses of the same cycle.
          if (gif.btn_sel) begin
            if (!face_up_q[cursor_q]) begin
              face_up_d[cursor_q] = 1'b1;
              if (state_q == SEL1) begin
                first_d = cursor_q;
                state_d = SEL2;
              end else begin
                second_d = cursor_q;
                state_d  = CMP;
              end
            end
          end else if (gif.btn_up)    cursor_d = cursor_q - 4'd4;
          else if (gif.btn_down)      cursor_d = cursor_q + 4'd4;
          else if (gif.btn_left)      cursor_d = cursor_q - 4'd1;
          else if (gif.btn_right)     cursor_d = cursor_q + 4'd1;
        end
        CMP: begin
          attempts_d = sat_inc8(attempts_q);
          if (pair_id(first_q) == pair_id(second_q)) begin
            matched_d[first_q]  = 1'b1;
            matched_d[second_q] = 1'b1;
            score_d             = score_q + 4'd1;
            state_d             = (score_q == 4'(PAIRS - 1)) ? DONE : SEL1;
          end else begin
            tmr_load = 1'b1;
            state_d  = SHOW;
          end
        end
        SHOW: begin
          if (tmr_done) begin
            face_up_d[first_q]  = 1'b0;
            face_up_d[second_q] = 1'b0;
            state_d             = SEL1;
          end
        end
        DONE: ;
        default: state_d = SEL1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEL1;
      cursor_q   <= '0;
      face_up_q  <= '0;
      matched_q  <= '0;
      score_q    <= '0;
      attempts_q <= '0;
      first_q    <= '0;
      second_q   <= '0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      face_up_q  <= face_up_d;
      matched_q  <= matched_d;
      score_q    <= score_d;
      attempts_q <= attempts_d;
      first_q    <= first_d;
      second_q   <= second_d;
    end
  end

  assign gif.cursor_pos = cursor_q;
  assign gif.face_up    = face_up_q;
  assign gif.matched    = matched_q;
  assign gif.score      = score_q;
  assign gif.attempts   = attempts_q;
  assign gif.game_done  = (state_q == DONE);
endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl with a short reveal time: a vector table
// for single-cycle behaviour plus sequences for full game, reset and saturation.
module tb_memory_game_ctrl;
  logic clk;
  logic rst_n;

  memory_game_ctrl_if gif();

  memory_game_ctrl #(.REVEAL_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gif   (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Button bit order: {start, up, down, left, right, sel}
  localparam logic [5:0] B_NO  = 6'b000000;
  localparam logic [5:0] B_ST  = 6'b100000;
  localparam logic [5:0] B_UP  = 6'b010000;
  localparam logic [5:0] B_DN  = 6'b001000;
  localparam logic [5:0] B_LT  = 6'b000100;
  localparam logic [5:0] B_RT  = 6'b000010;
  localparam logic [5:0] B_SEL = 6'b000001;

  typedef struct {
    logic [5:0]  btn;
    logic [3:0]  cur;
    logic [15:0] fu;
    logic [15:0] mt;
    logic [3:0]  sc;
    logic [7:0]  at;
    logic        dn;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input logic [5:0] b);
    gif.start     = b[5];
    gif.btn_up    = b[4];
    gif.btn_down  = b[3];
    gif.btn_left  = b[2];
    gif.btn_right = b[1];
    gif.btn_sel   = b[0];
  endtask

  task automatic step(input logic [5:0] b);
    drive(b);
    @(posedge clk);
    #1;
    drive(B_NO);
  endtask

  task automatic add(input logic [5:0] b, input logic [3:0] cur, input logic [15:0] fu,
                     input logic [15:0] mt, input logic [3:0] sc, input logic [7:0] at,
                     input logic dn);
    vec_t v;
    v.btn = b; v.cur = cur; v.fu = fu; v.mt = mt; v.sc = sc; v.at = at; v.dn = dn;
    tbl.push_back(v);
  endtask

  task automatic chk_all(input string nm, input logic [3:0] cur, input logic [15:0] fu,
                         input logic [15:0] mt, input logic [3:0] sc, input logic [7:0] at,
                         input logic dn);
    chk({nm, " cursor"},   gif.cursor_pos, cur);
    chk({nm, " face_up"},  gif.face_up,    fu);
    chk({nm, " matched"},  gif.matched,    mt);
    chk({nm, " score"},    gif.score,      sc);
    chk({nm, " attempts"}, gif.attempts,   at);
    chk({nm, " done"},     gif.game_done,  dn);
  endtask

  task automatic goto(input logic [3:0] pos);
    for (int k = 0; k < 16 && gif.cursor_pos != pos; k++) step(B_RT);
    chk($sformatf("goto %0d", pos), gif.cursor_pos, pos);
  endtask

  int          pa[8] = '{0, 1, 2, 3, 4, 6, 7, 8};
  int          pb[8] = '{5, 9, 10, 12, 14, 11, 13, 15};
  logic [15:0] mask;

  initial begin
    rst_n = 1'b0;
    drive(B_NO);
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    rst_n = 1'b1;

    // Cursor movement, wrap-around and priority
    add(B_RT, 4'd1,  16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_RT, 4'd2,  16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_RT, 4'd3,  16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_RT, 4'd4,  16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_RT, 4'd5,  16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_UP, 4'd1,  16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_LT, 4'd0,  16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_LT, 4'd15, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_DN, 4'd3,  16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_UP | B_DN | B_LT | B_RT, 4'd15, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_DN | B_LT, 4'd3, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_LT | B_RT, 4'd2, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_ST | B_SEL | B_RT, 4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    // Matching pair 0 and 5
    add(B_SEL, 4'd0, 16'h0001, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_RT,  4'd1, 16'h0001, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_RT,  4'd2, 16'h0001, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_RT,  4'd3, 16'h0001, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_RT,  4'd4, 16'h0001, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_RT,  4'd5, 16'h0001, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_SEL, 4'd5, 16'h0021, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_NO,  4'd5, 16'h0021, 16'h0021, 4'd1, 8'd1, 1'b0);
    add(B_SEL, 4'd5, 16'h0021, 16'h0021, 4'd1, 8'd1, 1'b0);
    add(B_LT,  4'd4, 16'h0021, 16'h0021, 4'd1, 8'd1, 1'b0);
    add(B_ST,  4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    // Mismatch 0/1, four reveal cycles with ignored buttons
    add(B_SEL, 4'd0, 16'h0001, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_RT,  4'd1, 16'h0001, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_SEL, 4'd1, 16'h0003, 16'h0, 4'd0, 8'd0, 1'b0);
    add(B_NO,  4'd1, 16'h0003, 16'h0, 4'd0, 8'd1, 1'b0);
    add(B_SEL, 4'd1, 16'h0003, 16'h0, 4'd0, 8'd1, 1'b0);
    add(B_SEL, 4'd1, 16'h0003, 16'h0, 4'd0, 8'd1, 1'b0);
    add(B_RT,  4'd1, 16'h0003, 16'h0, 4'd0, 8'd1, 1'b0);
    add(B_SEL, 4'd1, 16'h0000, 16'h0, 4'd0, 8'd1, 1'b0);
    // Re-select of own first card in SEL2, then select+move together
    add(B_SEL, 4'd1, 16'h0002, 16'h0, 4'd0, 8'd1, 1'b0);
    add(B_SEL, 4'd1, 16'h0002, 16'h0, 4'd0, 8'd1, 1'b0);
    add(B_RT,  4'd2, 16'h0002, 16'h0, 4'd0, 8'd1, 1'b0);
    add(B_SEL | B_RT, 4'd2, 16'h0006, 16'h0, 4'd0, 8'd1, 1'b0);
    add(B_NO,  4'd2, 16'h0006, 16'h0, 4'd0, 8'd2, 1'b0);
    add(B_NO,  4'd2, 16'h0006, 16'h0, 4'd0, 8'd2, 1'b0);
    add(B_NO,  4'd2, 16'h0006, 16'h0, 4'd0, 8'd2, 1'b0);
    add(B_NO,  4'd2, 16'h0006, 16'h0, 4'd0, 8'd2, 1'b0);
    add(B_NO,  4'd2, 16'h0000, 16'h0, 4'd0, 8'd2, 1'b0);
    add(B_ST,  4'd0, 16'h0000, 16'h0, 4'd0, 8'd0, 1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].btn);
      chk_all($sformatf("v%0d", i), tbl[i].cur, tbl[i].fu, tbl[i].mt,
              tbl[i].sc, tbl[i].at, tbl[i].dn);
    end

    // Full game with minimal selections
    step(B_ST);
    mask = '0;
    for (int p = 0; p < 8; p++) begin
      goto(4'(pa[p]));
      step(B_SEL);
      goto(4'(pb[p]));
      step(B_SEL);
      step(B_NO);
      mask = mask | (16'h1 << pa[p]) | (16'h1 << pb[p]);
      chk_all($sformatf("pair%0d", p), 4'(pb[p]), mask, mask, 4'(p + 1), 8'(p + 1),
              (p == 7));
    end
    step(B_SEL);
    step(B_LT);
    step(B_UP | B_SEL);
    chk_all("done hold", 4'd15, 16'hFFFF, 16'hFFFF, 4'd8, 8'd8, 1'b1);
    step(B_ST);
    chk_all("restart", 4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    step(B_RT);
    chk("restart move", gif.cursor_pos, 4'd1);

    // Reset during the second reveal cycle
    step(B_ST);
    step(B_SEL);
    step(B_RT);
    step(B_SEL);
    step(B_NO);
    step(B_NO);
    rst_n = 1'b0;
    #1;
    chk_all("async rst", 4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) step(B_NO);
    chk("post-rst face_up", gif.face_up, 16'h0);
    step(B_SEL);
    chk_all("post-rst sel", 4'd0, 16'h0001, 16'h0, 4'd0, 8'd0, 1'b0);

    // Attempts saturate at 255
    step(B_ST);
    for (int r = 0; r < 256; r++) begin
      step(B_SEL);
      step(B_RT);
      step(B_SEL);
      step(B_NO);
      repeat (4) step(B_NO);
      step(B_LT);
    end
    chk_all("saturate", 4'd0, 16'h0, 16'h0, 4'd0, 8'd255, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/memory_game_ctrl.md
MEMORY_GAME_CTRL -- requirements
Module: memory_game_ctrl

Interface
REQ-001 SHALL have parameter REVEAL_CYCLES, default 50_000_000, giving cycles a mismatched pair stays face-up.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk  in  1  system clock; all logic on its rising edge.
REQ-004 Port rst_n  in  1  asynchronous active-low reset.
REQ-005 Port start  in  1  one-cycle pulse; starts a new game.
REQ-006 Port btn_up, btn_down, btn_left, btn_right  in  1 each  one-cycle debounced move pulses.
REQ-007 Port btn_sel  in  1  one-cycle pulse; flips the card under the cursor.
REQ-008 Port cursor_pos  out  4  selected grid position, row-major 4x4 (0..15); drives the card renderer pos.
REQ-009 Port face_up  out  16  bit p=1: card p is shown face-up (renderer enable).
REQ-010 Port matched  out  16  bit p=1: card p is permanently matched.
REQ-011 Port score  out  4  pairs matched, 0..8.
REQ-012 Port attempts  out  8  pair comparisons made, saturating at 255.
REQ-013 Port game_done  out  1  high while in DONE.

Function
REQ-014 SHALL implement FSM states SEL1, SEL2, CMP, SHOW, DONE.
REQ-015 Cursor moves SHALL apply only in SEL1/SEL2: right +1, left -1, down +4, up -4, all mod 16; result visible the next cycle.
REQ-016 Simultaneous move pulses SHALL use priority up > down > left > right; btn_sel in the same cycle SHALL win, and all moves that cycle are dropped.
REQ-017 In SEL1, btn_sel on a card with face_up=0 SHALL set face_up[cursor], latch first=cursor, and go to SEL2 next cycle; btn_sel on a face-up card is ignored.
REQ-018 In SEL2, btn_sel on a card with face_up=0 SHALL set face_up[cursor], latch second=cursor, and go to CMP next cycle.
REQ-019 CMP SHALL last exactly one cycle and increment attempts (saturating).
REQ-020 On CMP, if LAYOUT[first]==LAYOUT[second], it SHALL set both matched bits, keep them face-up, and increment score. It then goes to DONE if the new score is 8, else to SEL1.
REQ-021 On CMP with a mismatch, it SHALL load the reveal counter with REVEAL_CYCLES and go to SHOW.
REQ-022 SHOW SHALL last exactly REVEAL_CYCLES cycles, then clear face_up[first] and face_up[second] and go to SEL1; buttons are ignored throughout.
REQ-023 DONE SHALL hold all outputs and drive game_done=1, ignoring all buttons except start.
REQ-024 start in any state SHALL, next cycle, clear face_up, matched, score, attempts and the counter, set cursor_pos=0, and go to SEL1; start overrides every other input that cycle.
REQ-025 face_up SHALL always be a superset of matched.

Reset
REQ-026 On rst_n=0: state SHALL be SEL1, cursor_pos=0, face_up=0, matched=0, score=0, attempts=0, game_done=0, and the reveal counter cleared.
REQ-027 Reset asserted mid-SHOW SHALL abort the reveal immediately, with no residual face_up bits after release.

Structure
REQ-028 A shared package SHALL hold the state enum, the GRID=16 and PAIRS=8 constants, and LAYOUT[0..15] = {0,1,2,3,4,0,5,6,7,1,2,5,3,6,4,7}, giving each card position its 3-bit pair ID.
REQ-029 The reveal countdown SHALL be one sub-module, reveal_timer (load, count, done pulse), parameterised by REVEAL_CYCLES.

Verification (REVEAL_CYCLES=4)
REQ-030 Reset, then right x5 and up x1 -> cursor_pos=5 then 1; with left from 0 -> cursor_pos=15.
REQ-031 sel at 0, right x5, sel at 5 -> CMP one cycle, then matched=0x0021, face_up=0x0021, score=1, attempts=1, state SEL1.
REQ-032 sel at 0, sel at 1 (mismatch) -> face_up=0x0003 for exactly 4 SHOW cycles, then 0x0000, attempts=1, score=0; sel pulses during SHOW have no effect.
REQ-033 In SEL2 with first=0, sel again at 0 -> ignored, state stays SEL2; in the same cycle as btn_sel and btn_right at cursor 2 -> card 2 flips and cursor_pos stays 2.
REQ-034 Match all 8 pairs with minimal selections -> score=8, attempts=8, matched=0xFFFF, game_done=1; then start -> everything cleared and state SEL1.
REQ-035 Assert rst_n during SHOW cycle 2 -> all outputs at reset values; after release, the first sel flips only the card under the cursor.
